// File: rtl/bytecode_pkg.sv
// Shared constants, opcodes, FSM encoding and length table for the
// bytecode fetch stage and the decoder.
package bytecode_pkg;

  localparam int BYTE_W    = 8;
  localparam int WIDTH_OUT = 4 * BYTE_W;
  localparam int ADDR_W    = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  localparam logic [7:0] ICONST_0        = 8'h03;
  localparam logic [7:0] BIPUSH          = 8'h10;
  localparam logic [7:0] SIPUSH          = 8'h11;
  localparam logic [7:0] LDC             = 8'h12;
  localparam logic [7:0] LDC_W           = 8'h13;
  localparam logic [7:0] LDC2_W          = 8'h14;
  localparam logic [7:0] ILOAD           = 8'h15;
  localparam logic [7:0] ALOAD           = 8'h19;
  localparam logic [7:0] ISTORE          = 8'h36;
  localparam logic [7:0] ASTORE          = 8'h3a;
  localparam logic [7:0] IINC            = 8'h84;
  localparam logic [7:0] IFEQ            = 8'h99;
  localparam logic [7:0] JSR             = 8'ha8;
  localparam logic [7:0] RET             = 8'ha9;
  localparam logic [7:0] TABLESWITCH     = 8'haa;
  localparam logic [7:0] LOOKUPSWITCH    = 8'hab;
  localparam logic [7:0] GETSTATIC       = 8'hb2;
  localparam logic [7:0] INVOKESTATIC    = 8'hb8;
  localparam logic [7:0] INVOKEINTERFACE = 8'hb9;
  localparam logic [7:0] INVOKEDYNAMIC   = 8'hba;
  localparam logic [7:0] NEW             = 8'hbb;
  localparam logic [7:0] NEWARRAY        = 8'hbc;
  localparam logic [7:0] ANEWARRAY       = 8'hbd;
  localparam logic [7:0] CHECKCAST       = 8'hc0;
  localparam logic [7:0] INSTANCEOF      = 8'hc1;
  localparam logic [7:0] WIDE            = 8'hc4;
  localparam logic [7:0] MULTIANEWARRAY  = 8'hc5;
  localparam logic [7:0] IFNULL          = 8'hc6;
  localparam logic [7:0] IFNONNULL       = 8'hc7;
  localparam logic [7:0] GOTO_W          = 8'hc8;
  localparam logic [7:0] JSR_W           = 8'hc9;
  localparam logic [7:0] BREAKPOINT      = 8'hca;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    PRESENT   = 2'd2
  } state_t;

  // Returns {illegal, total instruction length in bytes}.
  function automatic logic [3:0] opcode_length(input logic [7:0] op);
    logic [3:0] r;
    r = {1'b0, 3'd1};
    unique case (1'b1)
      (op == BIPUSH) || (op == LDC) ||
      (op >= ILOAD && op <= ALOAD) ||
      (op >= ISTORE && op <= ASTORE) ||
      (op == RET) || (op == NEWARRAY):
        r = {1'b0, 3'd2};
      (op == SIPUSH) || (op == LDC_W) ||
      (op == LDC2_W) || (op == IINC) ||
      (op >= IFEQ && op <= JSR) ||
      (op >= GETSTATIC && op <= INVOKESTATIC) ||
      (op == NEW) || (op == ANEWARRAY) ||
      (op == CHECKCAST) || (op == INSTANCEOF) ||
      (op == IFNULL) || (op == IFNONNULL):
        r = {1'b0, 3'd3};
      (op == MULTIANEWARRAY):
        r = {1'b0, 3'd4};
      (op == INVOKEINTERFACE) ||
      (op == INVOKEDYNAMIC) ||
      (op == GOTO_W) || (op == JSR_W):
        r = {1'b1, 3'd5};
      (op == TABLESWITCH) ||
      (op == LOOKUPSWITCH) ||
      (op == WIDE) || (op > BREAKPOINT):
        r = {1'b1, 3'd1};
      default:
        r = {1'b0, 3'd1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bytecode_fetch_len.sv
// Combinational opcode length / legality lookup, shared with the decoder.
module opcode_length_rom
  import bytecode_pkg::*;
(
  input  logic [BYTE_W-1:0] opcode,
  output logic [2:0]        len,
  output logic              illegal
);

  assign {illegal, len} = opcode_length(opcode);

endmodule

// File: rtl/bytecode_fetch.sv
// Walks the bytecode stream and assembles variable-length instructions
// into left-aligned 32-bit words for the decoder.
module bytecode_fetch
  import bytecode_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_start,
  output logic [ADDR_W-1:0]    mem_address,
  input  logic [BYTE_W-1:0]    mem_data,
  input  logic                 mem_ready,
  output logic                 start,
  input  logic                 ready,
  output logic [WIDTH_OUT-1:0] instruction_out,
  output logic [ADDR_W-1:0]    pc_out,
  output logic                 illegal,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_pc
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, addr;
  logic [2:0]        len, cnt, last;
  logic [2:0]        op_len;
  logic              op_ill;
  logic              idle;

  opcode_length_rom u_len (
    .opcode  (mem_data),
    .len     (op_len),
    .illegal (op_ill)
  );

  // Five-byte opcodes only ever deliver their first four bytes.
  assign last = (len > 3'd4) ? 3'd4 : len;

  // idle blanks the request for one cycle after reset or redirect.
  assign mem_start   = (state != PRESENT) && !idle;
  assign mem_address = (state == FETCH_ARG) ? addr : pc;
  assign start       = (state == PRESENT);

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH_OP:
        if (mem_ready && !idle)
          state_n = (op_len == 3'd1) ? PRESENT : FETCH_ARG;
      FETCH_ARG:
        if (mem_ready && (cnt + 3'd1 == last))
          state_n = PRESENT;
      PRESENT:
        if (ready)
          state_n = FETCH_OP;
      default:
        state_n = FETCH_OP;
    endcase
    if (redirect)
      state_n = FETCH_OP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= FETCH_OP;
      pc              <= RESET_PC;
      addr            <= RESET_PC;
      len             <= 3'd1;
      cnt             <= 3'd0;
      idle            <= 1'b1;
      instruction_out <= '0;
      pc_out          <= '0;
      illegal         <= 1'b0;
    end else begin
      state <= state_n;
      idle  <= redirect;
      if (redirect) begin
        pc  <= redirect_pc;
        cnt <= 3'd0;
      end else begin
        case (state)
          FETCH_OP: begin
            if (mem_ready && !idle) begin
              instruction_out <= {mem_data, {(WIDTH_OUT-BYTE_W){1'b0}}};
              pc_out          <= pc;
              len             <= op_len;
              illegal         <= op_ill;
              addr            <= pc + ADDR_W'(1);
              cnt             <= 3'd1;
            end
          end
          FETCH_ARG: begin
            if (mem_ready) begin
              case (cnt)
                3'd1:    instruction_out[23:16] <= mem_data;
                3'd2:    instruction_out[15:8]  <= mem_data;
                default: instruction_out[7:0]   <= mem_data;
              endcase
              addr <= addr + ADDR_W'(1);
              cnt  <= cnt + 3'd1;
            end
          end
          PRESENT: begin
            if (ready)
              pc <= pc_out + ADDR_W'(len);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/bytecode_fetch.md
Name: bytecode_fetch

Overview:
Upstream neighbour of the bytecode decoder. Walks the JVM bytecode stream in a byte-wide memory from a program counter and assembles each variable-length instruction (opcode plus up to 3 operand bytes) into one left-aligned 32-bit word. It presents each word to the decoder over a start/ready handshake. Accepts a redirect (branch/jump target) from downstream and restarts fetching there.

Parameters:
byte, 8, bits per bytecode byte
width_out, 32 (4*byte), width of the assembled instruction word
address_size, 16, bytecode memory address width
RESET_PC, 16'h0000, PC loaded on reset

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high; clears all state on the clock edge where high
mem_start  output  1  byte-read request to bytecode memory, level
mem_address  output  address_size  byte address of current request
mem_data  input  byte  read data, valid when mem_ready=1
mem_ready  input  1  read complete this cycle (may be high in the same cycle as mem_start)
start  output  1  instruction word valid to decoder
ready  input  1  decoder accepts the word this cycle
instruction_out  output  width_out  [31:24]=opcode, [23:16]=op1, [15:8]=op2, [7:0]=op3; unused bytes 0
pc_out  output  address_size  address of the opcode of instruction_out
illegal  output  1  qualifies instruction_out: opcode unsupported (see below)
redirect  input  1  one-cycle pulse: discard current work, continue at redirect_pc
redirect_pc  input  address_size  new PC

Behaviour:
- Reset (on edge with reset=1): state=FETCH_OP, pc=RESET_PC, byte counter=0, mem_start=0, mem_address=RESET_PC, start=0, instruction_out=0, pc_out=0, illegal=0. First request (mem_start=1) appears in the first cycle after reset deasserts. Reset mid-fetch or mid-handshake aborts everything. Any pending memory byte is ignored.
- States: FETCH_OP, FETCH_ARG, PRESENT.
- FETCH_OP: mem_start=1, mem_address=pc. On edge with mem_ready=1: opcode→[31:24], lower bytes cleared, pc_out<=pc, len<=opcode_length(opcode), addr<=pc+1. If len==1 go PRESENT, else FETCH_ARG.
- FETCH_ARG: mem_start=1, mem_address=addr. Each mem_ready captures the next byte into the next lower byte lane and increments addr. After byte len-1 (capped at 4 bytes total), go PRESENT.
- PRESENT: mem_start=0, start=1, instruction_out/pc_out/illegal held stable. On edge with ready=1: pc<=pc_out+len, go FETCH_OP. start drops the cycle after.
- Timing with mem_ready always 1: an N-byte instruction whose opcode is requested in cycle t has start=1 in cycle t+N. Back-to-back 1-byte instructions with ready=1 take 2 cycles each.
- Length table: 1 by default. 2 for bipush, ldc, *load/*store idx (0x15–0x19, 0x36–0x3a), ret, newarray. 3 for sipush, ldc_w, ldc2_w, iinc, if*/goto/jsr (0x99–0xa8), get/put/invoke(virtual/special/static), new, anewarray, checkcast, instanceof, ifnull, ifnonnull, multianewarray (byte3 is dims, so total 4).
- Illegal: tableswitch 0xaa, lookupswitch 0xab, wide 0xc4, and 0xcb–0xff: length 1, illegal=1. 5-byte opcodes 0xb9, 0xba, 0xc8, 0xc9: first 4 bytes emitted, illegal=1, pc advances 5.
- PC arithmetic wraps modulo 2^address_size. No fault on wrap.
- Redirect takes priority in any state: pc<=redirect_pc, state=FETCH_OP, start=0 and mem_start=0 next cycle, partial word discarded, fetch resumes the following cycle.
- Redirect in the same cycle as a PRESENT transfer (start&ready): the transfer counts, and pc takes redirect_pc.
- reset outranks redirect.

Decomposition:
- Package bytecode_pkg: byte/width constants, opcode localparams (ICONST_0=8'h03, BIPUSH=8'h10, SIPUSH=8'h11, TABLESWITCH=8'haa, ...), state encoding, and function opcode_length(opcode)→{illegal, len[2:0]}. The decoder shares the same package.
- One sub-module: opcode_length_rom (combinational wrapper of the function) so the decoder can reuse it.

Test Plan:
- Memory 03 04 at 0x0000, ready=1, mem_ready=1 → instruction_out 32'h03000000 pc_out 0, then 32'h04000000 pc_out 1, one start cycle each.
- bipush 10 7F then sipush 11 12 34 → 32'h107F0000 pc_out 0, then 32'h11123400 pc_out 2, next opcode fetched at 5.
- Decoder stall: ready low 6 cycles during PRESENT → start and instruction_out stable, mem_start=0, no address change; release → pc advances once.
- redirect=1, redirect_pc=16'h0040 during FETCH_ARG of sipush → partial word dropped, next mem_address 0x0040, next word from 0x0040.
- Opcode 0xAA at 0x0010 → 32'hAA000000 with illegal=1; 0xB9 01 02 03 04 → 32'hB9010203 with illegal=1, next fetch at pc+5.
- reset asserted mid-FETCH_ARG → next cycle all outputs at reset values; first request after release at RESET_PC.
